// File: rtl/simon_pkg.sv
// simon_pkg: Simon 32/64 constants, round function and round-key type,
// shared by the encrypt and decrypt pipelines.
package simon_pkg;
    localparam int SIMON_WORD   = 16;
    localparam int SIMON_ROUNDS = 32;
    // Bit j (LSB first) is element j of the Simon z0 sequence
    localparam logic [61:0] SIMON_Z0 = 62'h19C3_522F_B386_A45F;
    localparam logic [SIMON_WORD-1:0] SIMON_C = 16'hFFFC;

    typedef logic [SIMON_WORD-1:0] simon_word_t;
    typedef simon_word_t [SIMON_ROUNDS-1:0] simon_rk_t;

    function automatic simon_word_t simon_f(simon_word_t v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction
endpackage

// File: rtl/simon_key_schedule.sv
// simon_key_schedule: combinational Simon 32/64 key expansion, 64-bit key to
// 32 round keys (k0 taken from key_i[15:0]).
module simon_key_schedule
    import simon_pkg::*;
(
    input  logic [63:0] key_i,
    output simon_rk_t   rk_o
);
    simon_word_t t;

    // ~k ^ 3 is folded into a single XOR with SIMON_C
    always_comb begin
        t = '0;
        rk_o = '0;
        rk_o[3:0] = key_i;
        for (int i = 4; i < SIMON_ROUNDS; i++) begin
            t = {rk_o[i-1][2:0], rk_o[i-1][15:3]} ^ rk_o[i-3];
            t = t ^ {t[0], t[15:1]};
            rk_o[i] = rk_o[i-4] ^ SIMON_C ^ t ^ {15'd0, SIMON_Z0[i-4]};
        end
    end
endmodule

// File: rtl/simon_decrypt_pipeline.sv
// simon_decrypt_pipeline: 32-round fully pipelined Simon 32/64 decryptor,
// one block per clock, 32-cycle latency. SIMON_DEC_KEY_PORT_EN adds key/key_load.
module simon_decrypt_pipeline
    import simon_pkg::*;
#(
    parameter logic [63:0] DEFAULT_KEY = 64'h1918_1110_0908_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] ciphertext,
`ifdef SIMON_DEC_KEY_PORT_EN
    input  logic [63:0] key,
    input  logic        key_load,
`endif
    output logic        out_valid,
    output logic [31:0] plaintext,
    output logic        busy
);
    logic [63:0]         key_q;
    simon_rk_t           rk;
    logic [SIMON_ROUNDS:0] v_q, en;
    simon_word_t         x_q [SIMON_ROUNDS+1];
    simon_word_t         y_q [SIMON_ROUNDS+1];
    simon_word_t         x_d [SIMON_ROUNDS+1];
    simon_word_t         y_d [SIMON_ROUNDS+1];

`ifdef SIMON_DEC_KEY_PORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_q <= DEFAULT_KEY;
        else if (key_load) key_q <= key;
    end
`else
    assign key_q = DEFAULT_KEY;
`endif

    simon_key_schedule u_ks (.key_i(key_q), .rk_o(rk));

    // Stage 0 only captures the block, so a same-cycle key_load already
    // applies to its first round.
    assign x_d[0] = ciphertext[31:16];
    assign y_d[0] = ciphertext[15:0];
    assign en     = {v_q[SIMON_ROUNDS-1:0], in_valid};

    for (genvar s = 0; s < SIMON_ROUNDS; s++) begin : g_round
        assign x_d[s+1] = y_q[s];
        assign y_d[s+1] = x_q[s] ^ simon_f(y_q[s]) ^ rk[SIMON_ROUNDS-1-s];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            for (int s = 0; s <= SIMON_ROUNDS; s++) begin
                x_q[s] <= '0;
                y_q[s] <= '0;
            end
        end else begin
            v_q <= en;
            for (int s = 0; s <= SIMON_ROUNDS; s++) begin
                if (en[s]) begin
                    x_q[s] <= x_d[s];
                    y_q[s] <= y_d[s];
                end
            end
        end
    end

    assign out_valid = v_q[SIMON_ROUNDS];
    assign plaintext = {x_q[SIMON_ROUNDS], y_q[SIMON_ROUNDS]};
    assign busy      = |v_q;
endmodule

// File: tb/tb_simon_decrypt_pipeline.sv
// tb_simon_decrypt_pipeline: directed + random blocks checked against a
// word-level Simon 32/64 encrypt model and a timestamped expectation queue.
module tb_simon_decrypt_pipeline;
    localparam logic [63:0] DEF_KEY = 64'h1918_1110_0908_0100;

    typedef struct {
        int          a;
        logic [31:0] pt;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 1;
    logic        in_valid = 0;
    logic [31:0] ciphertext = 0;
    logic        out_valid, busy;
    logic [31:0] plaintext;
`ifdef SIMON_DEC_KEY_PORT_EN
    logic [63:0] key = 0;
    logic        key_load = 0;
`endif

    int          nchk = 0, nerr = 0, cyc = 0;
    exp_t        q[$];
    logic [31:0] last_pt = 0;
    logic [63:0] mkey = DEF_KEY;
    string       z0 = "11111010001001010110000111001101111101000100101011000011100110";

    simon_decrypt_pipeline dut (
        .clk(clk),
        .rst(rst_n),
        .in_valid(in_valid),
        .ciphertext(ciphertext),
`ifdef SIMON_DEC_KEY_PORT_EN
        .key(key),
        .key_load(key_load),
`endif
        .out_valid(out_valid),
        .plaintext(plaintext),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rol(logic [15:0] v, int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [15:0] ror(logic [15:0] v, int n);
        return (v >> n) | (v << (16 - n));
    endfunction

    function automatic logic [31:0] enc(logic [31:0] pt, logic [63:0] k64);
        logic [15:0] k [32];
        logic [15:0] x, y, t;
        for (int i = 0; i < 4; i++) k[i] = k64[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = ror(k[i-1], 3) ^ k[i-3];
            t = t ^ ror(t, 1);
            k[i] = ~k[i-4] ^ t ^ 16'(z0[i-4] == "1") ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int r = 0; r < 32; r++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ k[r];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s at cycle %0d: observed %h, expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle();
        logic eb, ev;
        eb = q.size() != 0;
        ev = eb && (q[0].a + 32 == cyc);
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("busy", {31'd0, busy}, {31'd0, eb});
        if (ev) begin
            last_pt = q[0].pt;
            void'(q.pop_front());
        end
        chk(ev ? "plaintext" : "plaintext_hold", plaintext, last_pt);
    endtask

    task automatic drive(input logic v, input logic [31:0] ct, input logic [31:0] expv);
        in_valid = v;
        ciphertext = v ? ct : $urandom;
        @(posedge clk);
        cyc++;
        if (v) q.push_back('{cyc, expv});
        @(negedge clk);
        in_valid = 0;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic send(input logic [31:0] pt);
        drive(1, enc(pt, mkey), pt);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        #1;
        q.delete();
        last_pt = 0;
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_plaintext", plaintext, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [31:0] pt;
        @(negedge clk);
        do_reset();
        idle(2);

        // Known-answer block with the default key
        drive(1, 32'hC69BE9BB, 32'h65656877);
        idle(34);

        // Back-to-back
        send(32'h41424344);
        send(32'h77686565);
        send(32'h65656877);
        idle(34);

        // Gapped: valid, idle, idle, valid
        send($urandom);
        idle(2);
        send($urandom);
        idle(34);

        // Reset mid-flight: 10 blocks, reset at cycle 15
        for (int i = 0; i < 10; i++) send($urandom);
        idle(5);
        do_reset();
        idle(40);
        send($urandom);
        idle(34);

`ifdef SIMON_DEC_KEY_PORT_EN
        key = 64'h0;
        key_load = 1;
        drive(0, 0, 0);
        key_load = 0;
        mkey = 64'h0;
        send(32'h41424344);
        idle(34);
        // Key load together with a block: block uses the new key
        key = DEF_KEY;
        key_load = 1;
        mkey = DEF_KEY;
        pt = $urandom;
        in_valid = 1;
        drive(1, enc(pt, mkey), pt);
        key_load = 0;
        idle(34);
`endif

        // Random round trip
        for (int i = 0; i < 300; i++) begin
            pt = $urandom;
            drive($urandom_range(0, 3) != 0, enc(pt, mkey), pt);
        end
        idle(34);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/simon_decrypt_pipeline.md
# simon_decrypt_pipeline

Fully pipelined Simon 32/64 decryptor: the inverse of `simon_pipeline`, turning 32-bit ciphertext blocks back into plaintext. It sits on the receive side of the link. It accepts one block per clock and returns each plaintext exactly 32 cycles later. Round keys come from a 64-bit key register, expanded by a key-schedule sub-module and applied in reverse order.

## Interface
- `DEFAULT_KEY`, 64'h1918_1110_0908_0100: value loaded into the key register at reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `ciphertext` holds a block this cycle.
- `ciphertext` in 32: {x[31:16], y[15:0]}, the same word order the encryptor produces.
- `key` in 64: {k3,k2,k1,k0}, k0 in [15:0]. Present only with `SIMON_DEC_KEY_PORT_EN`.
- `key_load` in 1: one-cycle strobe that captures `key`. Present only with `SIMON_DEC_KEY_PORT_EN`.
- `out_valid` out 1: `plaintext` is valid this cycle.
- `plaintext` out 32: decrypted block.
- `busy` out 1: OR of all stage valid bits.

## Operation
- 32 pipeline stages. Stage s (0..31) applies decrypt round r = 31-s with round key k[r].
- Round function on the 16-bit pair (x,y):
  - f(v) = (v<<<1 & v<<<8) ^ (v<<<2).
  - Next state: x' = y, y' = x ^ f(y) ^ k[r].
- Key schedule, word-wise on 16-bit words:
  - k[0..3] come from the key register.
  - For i = 4..31: t = k[i-1]>>>3 ^ k[i-3]; t ^= t>>>1; k[i] = ~k[i-4] ^ t ^ z0[(i-4)%62] ^ 3.
  - z0 is the Simon sequence z0.
- Each stage register carries x, y and a valid bit.
- Data registers load only when the valid bit entering the stage is 1. Bubbles propagate with data held, so `plaintext` changes only on `out_valid`.
- `key_load`:
  - The key register updates on the next edge, and the round keys are combinational from it.
  - Blocks in flight from that edge onward use the new keys; those outputs are not guaranteed correct.
  - The upstream rule is to load only when `busy` = 0.
  - `key_load` and `in_valid` in the same cycle: that block is decrypted with the new key.
- All arithmetic is 16-bit XOR/AND/rotate. No carries.

## Timing
- Reset (`rst` = 0, async):
  - All stage valids = 0 and all stage data = 0.
  - `out_valid` = 0, `plaintext` = 0, `busy` = 0.
  - Key register = `DEFAULT_KEY`.
- Latency: a block with `in_valid` = 1 at edge n gives `out_valid` = 1 with the matching `plaintext` after edge n+32.
- Throughput: one block per cycle with no stalls. There is no backpressure, so the consumer must accept every `out_valid`.
- Output order equals input order. Gaps in `in_valid` reappear as identical gaps on `out_valid`.
- Reset mid-operation: every in-flight block is discarded. The first post-reset output is the first block accepted after `rst` deasserts.
- `busy` is 1 from the edge that accepts a block until the edge after its `out_valid` cycle.

## Configuration
- Macro: `SIMON_DEC_KEY_PORT_EN`.
- Defined: the `key` and `key_load` ports exist and the key register is writable as described in Operation.
- Undefined:
  - The ports are absent and the key register is the constant `DEFAULT_KEY`.
  - Round keys are constants; synthesis folds the schedule.
  - `busy` is still generated.

## Structure
- `simon_pkg`:
  - `SIMON_WORD` = 16, `SIMON_ROUNDS` = 32.
  - 62-bit `SIMON_Z0` constant, `SIMON_C` = 16'hFFFC.
  - `simon_f` function, round-key array typedef.
  - Shared with `simon_pipeline`.
- Sub-module `simon_key_schedule`:
  - Combinational.
  - 64-bit key in, array of 32 round keys out.
  - Reusable by the encryptor.
- Top-level: a generate loop of 32 stage registers plus key-register logic.

## Test plan
- Reset, then a single block: `ciphertext` = 32'hC69BE9BB with default key → exactly 32 cycles later `out_valid` = 1, `plaintext` = 32'h65656877.
- Back-to-back: ciphertexts of 41424344, 77686565, 65656877 (produced by `simon_pipeline`) on three consecutive cycles → the three plaintexts on three consecutive cycles, in the same order.
- Gapped input: valid, idle, idle, valid → the output shows the same two idle cycles, and `plaintext` holds its value during the gaps.
- Reset mid-flight:
  - Drive 10 blocks and pulse `rst` low at cycle 15 → no `out_valid` for any of those blocks.
  - A block sent after reset emerges 32 cycles later.
- Key load (`SIMON_DEC_KEY_PORT_EN`): load 64'h0 while idle, then decrypt the encryptor output of 32'h41424344 under key 0 → 32'h41424344. Check that `busy` rises and falls at the specified edges.
- Round trip: random plaintexts through `simon_pipeline` into this block → every output equals the original plaintext with 64-cycle total latency.
